// File: rtl/vec_scalar_opnd_issue_if.sv
// vec_scalar_opnd_issue_if: decoder-in, regfile port-steal and issue-out
// bundle for the vector scalar-operand issue stage.
interface vec_scalar_opnd_issue_if #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int XLEN    = 64,
  parameter int RADDR_W = 6
);
  localparam int CW = $clog2(DEPTH + 1);

  logic               vins_valid_i;
  logic               vins_ready_o;
  logic [INSTR_W-1:0] vins_instr_i;
  logic               vins_use_rs1_i;
  logic [4:0]         vins_rs1_i;
  logic               rf_grant_i;
  logic               rs1_addr_Ven_o;
  logic [RADDR_W-1:0] rs1_addr_o;
  logic [XLEN-1:0]    rs1_data_i;
  logic               vissue_valid_o;
  logic               vissue_ready_i;
  logic [INSTR_W-1:0] vissue_instr_o;
  logic [XLEN-1:0]    vissue_scalar_o;
  logic [CW-1:0]      fifo_count_o;

  modport slave (
    input  vins_valid_i, vins_instr_i,
    input  vins_use_rs1_i, vins_rs1_i,
    input  rf_grant_i, rs1_data_i,
    input  vissue_ready_i,
    output vins_ready_o, rs1_addr_Ven_o,
    output rs1_addr_o, vissue_valid_o,
    output vissue_instr_o, vissue_scalar_o,
    output fifo_count_o
  );

  modport master (
    output vins_valid_i, vins_instr_i,
    output vins_use_rs1_i, vins_rs1_i,
    output rf_grant_i, rs1_data_i,
    output vissue_ready_i,
    input  vins_ready_o, rs1_addr_Ven_o,
    input  rs1_addr_o, vissue_valid_o,
    input  vissue_instr_o, vissue_scalar_o,
    input  fifo_count_o
  );
endinterface

// File: rtl/vec_scalar_opnd_issue.sv
// vec_scalar_opnd_issue: hold stage, scalar regfile port-1 steal and an
// in-order fall-through FIFO feeding the vector execution unit.
module vec_scalar_opnd_issue #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int XLEN    = 64,
  parameter int RADDR_W = 6
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic soft_rstn_i,
  input  logic flush_i,
  vec_scalar_opnd_issue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    scalar;
  } ent_t;

  logic               hold_valid;
  logic               hold_need;
  logic [INSTR_W-1:0] hold_instr;
  logic [4:0]         hold_rs1;

  ent_t          mem [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] count;

  logic kill;
  logic full;
  logic push;
  logic pop;
  logic need_in;
  logic rdy;
  logic accept;

  always_comb begin
    kill    = flush_i || !soft_rstn_i;
    full    = (count == FULL);
    push    = hold_valid && !full && !kill &&
              (!hold_need || bus.rf_grant_i);
    pop     = (count != '0) && bus.vissue_ready_i;
    need_in = bus.vins_use_rs1_i && (bus.vins_rs1_i != 5'd0);
    rdy     = !kill && (!hold_valid || push);
    accept  = bus.vins_valid_i && rdy;
  end

  // rstn_i only gates the output so it never reaches a flop data path
  assign bus.vins_ready_o    = rstn_i && rdy;
  assign bus.rs1_addr_Ven_o  = push && hold_need;
  assign bus.rs1_addr_o      = hold_valid ?
    {{(RADDR_W-5){1'b0}}, hold_rs1} : '0;
  assign bus.vissue_valid_o  = (count != '0);
  assign bus.vissue_instr_o  = mem[rptr].instr;
  assign bus.vissue_scalar_o = mem[rptr].scalar;
  assign bus.fifo_count_o    = count;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hold_valid <= 1'b0;
      hold_need  <= 1'b0;
      hold_instr <= '0;
      hold_rs1   <= '0;
    end else if (kill) begin
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_need  <= need_in;
      hold_instr <= bus.vins_instr_i;
      hold_rs1   <= bus.vins_rs1_i;
    end else if (push) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (kill) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= ent_t'{
          instr:  hold_instr,
          scalar: hold_need ? bus.rs1_data_i : '0
        };
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_scalar_opnd_issue.sv
// tb_vec_scalar_opnd_issue: directed plan scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_vec_scalar_opnd_issue;
  localparam int DEPTH   = 4;
  localparam int INSTR_W = 32;
  localparam int XLEN    = 64;
  localparam int RADDR_W = 6;

  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  logic soft_rstn_i = 1'b1;
  logic flush_i = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int ven_cnt = 0;
  int cyc = 0;

  logic [XLEN-1:0] rf [32];
  logic [31:0] popq [$];

  vec_scalar_opnd_issue_if #(
    .DEPTH(DEPTH), .INSTR_W(INSTR_W),
    .XLEN(XLEN), .RADDR_W(RADDR_W)
  ) bus ();

  vec_scalar_opnd_issue #(
    .DEPTH(DEPTH), .INSTR_W(INSTR_W),
    .XLEN(XLEN), .RADDR_W(RADDR_W)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .soft_rstn_i(soft_rstn_i),
    .flush_i(flush_i),
    .bus(bus)
  );

  // the bench plays the scalar regfile behind the stolen read port
  assign bus.rs1_data_i = rf[bus.rs1_addr_o[4:0]];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [63:0] scalar;
  } item_t;

  item_t       mq [$];
  bit          mh_v;
  bit          mh_need;
  logic [31:0] mh_instr;
  logic [4:0]  mh_rs1;

  always @(negedge clk_i) begin : model
    bit kill, full, push, rdy, pop, acc;
    item_t it;
    if (!rstn_i) begin
      check("rst_ready", 64'(bus.vins_ready_o), 64'd0);
      check("rst_ven", 64'(bus.rs1_addr_Ven_o), 64'd0);
      check("rst_addr", 64'(bus.rs1_addr_o), 64'd0);
      check("rst_vvalid", 64'(bus.vissue_valid_o), 64'd0);
      check("rst_count", 64'(bus.fifo_count_o), 64'd0);
      check("rst_instr", 64'(bus.vissue_instr_o), 64'd0);
      check("rst_scalar", bus.vissue_scalar_o, 64'd0);
      mq.delete();
      mh_v = 1'b0;
    end else begin
      kill = flush_i || !soft_rstn_i;
      full = (mq.size() == DEPTH);
      push = mh_v && !full && !kill &&
             (!mh_need || bus.rf_grant_i);
      rdy  = !kill && (!mh_v || push);
      check("m_ready", 64'(bus.vins_ready_o), 64'(rdy));
      check("m_ven", 64'(bus.rs1_addr_Ven_o),
            64'(push && mh_need));
      check("m_addr", 64'(bus.rs1_addr_o),
            mh_v ? 64'(mh_rs1) : 64'd0);
      check("m_vvalid", 64'(bus.vissue_valid_o),
            64'(mq.size() != 0));
      check("m_count", 64'(bus.fifo_count_o), 64'(mq.size()));
      if (mq.size() != 0) begin
        check("m_instr", 64'(bus.vissue_instr_o),
              64'(mq[0].instr));
        check("m_scalar", bus.vissue_scalar_o, mq[0].scalar);
      end
      if (bus.rs1_addr_Ven_o) ven_cnt++;
      if (bus.vissue_valid_o && bus.vissue_ready_i)
        popq.push_back(bus.vissue_instr_o);
      pop = (mq.size() != 0) && bus.vissue_ready_i;
      acc = bus.vins_valid_i && rdy;
      if (kill) begin
        mq.delete();
        mh_v = 1'b0;
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) begin
          it.instr  = mh_instr;
          it.scalar = mh_need ? rf[mh_rs1] : 64'd0;
          mq.push_back(it);
        end
        if (acc) begin
          mh_v     = 1'b1;
          mh_need  = bus.vins_use_rs1_i && (bus.vins_rs1_i != 5'd0);
          mh_instr = bus.vins_instr_i;
          mh_rs1   = bus.vins_rs1_i;
        end else if (push) begin
          mh_v = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [31:0] ins,
                      input bit use_rs1,
                      input logic [4:0] rs);
    bit done = 1'b0;
    bus.vins_valid_i   = 1'b1;
    bus.vins_instr_i   = ins;
    bus.vins_use_rs1_i = use_rs1;
    bus.vins_rs1_i     = rs;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk_i);
      done = bus.vins_ready_o;
      tick();
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: instr %0h never accepted", ins);
    end
    bus.vins_valid_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int c0;
    for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
    rf[0] = '0;
    rf[5] = 64'hDEADBEEF_0000_0005;
    bus.vins_valid_i   = 1'b0;
    bus.vins_instr_i   = '0;
    bus.vins_use_rs1_i = 1'b0;
    bus.vins_rs1_i     = '0;
    bus.rf_grant_i     = 1'b0;
    bus.vissue_ready_i = 1'b0;

    repeat (2) @(negedge clk_i);
    check("reset_ready_low", 64'(bus.vins_ready_o), 64'd0);
    tick();
    rstn_i = 1'b1;
    @(negedge clk_i);
    check("ready_after_rst", 64'(bus.vins_ready_o), 64'd1);
    tick();

    // scenario 1: no rs1 read, two-cycle latency
    bus.vins_valid_i = 1'b1;
    bus.vins_instr_i = 32'h0000_0057;
    @(negedge clk_i);
    check("s1_ready", 64'(bus.vins_ready_o), 64'd1);
    tick();
    bus.vins_valid_i = 1'b0;
    @(negedge clk_i);
    check("s1_n1_vvalid", 64'(bus.vissue_valid_o), 64'd0);
    tick();
    @(negedge clk_i);
    check("s1_n2_vvalid", 64'(bus.vissue_valid_o), 64'd1);
    check("s1_instr", 64'(bus.vissue_instr_o), 64'h57);
    check("s1_scalar", bus.vissue_scalar_o, 64'd0);
    check("s1_count", 64'(bus.fifo_count_o), 64'd1);
    tick();
    @(negedge clk_i);
    check("s1_count_hold", 64'(bus.fifo_count_o), 64'd1);
    tick();
    bus.vissue_ready_i = 1'b1;
    tick();
    bus.vissue_ready_i = 1'b0;
    @(negedge clk_i);
    check("s1_count_pop", 64'(bus.fifo_count_o), 64'd0);
    tick();

    // scenario 2: rs1=5 waits three cycles for the grant
    bus.vins_valid_i   = 1'b1;
    bus.vins_instr_i   = 32'h0050_5057;
    bus.vins_use_rs1_i = 1'b1;
    bus.vins_rs1_i     = 5'd5;
    @(negedge clk_i);
    check("s2_ready", 64'(bus.vins_ready_o), 64'd1);
    tick();
    bus.vins_valid_i = 1'b0;
    v0 = ven_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("s2_wait_ven", 64'(bus.rs1_addr_Ven_o), 64'd0);
      check("s2_wait_ready", 64'(bus.vins_ready_o), 64'd0);
      check("s2_wait_addr", 64'(bus.rs1_addr_o), 64'd5);
      tick();
    end
    bus.rf_grant_i = 1'b1;
    @(negedge clk_i);
    check("s2_ven", 64'(bus.rs1_addr_Ven_o), 64'd1);
    check("s2_addr", 64'(bus.rs1_addr_o), 64'd5);
    tick();
    bus.rf_grant_i = 1'b0;
    @(negedge clk_i);
    check("s2_vvalid", 64'(bus.vissue_valid_o), 64'd1);
    check("s2_scalar", bus.vissue_scalar_o, 64'hDEADBEEF_0000_0005);
    check("s2_ven_once", 64'(ven_cnt - v0), 64'd1);
    tick();
    bus.vissue_ready_i = 1'b1;
    tick();
    bus.vissue_ready_i = 1'b0;

    // scenario 3: rs1=x0 needs no read
    bus.vins_valid_i   = 1'b1;
    bus.vins_instr_i   = 32'h0000_2057;
    bus.vins_use_rs1_i = 1'b1;
    bus.vins_rs1_i     = 5'd0;
    v0 = ven_cnt;
    @(negedge clk_i);
    check("s3_ready", 64'(bus.vins_ready_o), 64'd1);
    tick();
    bus.vins_valid_i = 1'b0;
    @(negedge clk_i);
    check("s3_n1_vvalid", 64'(bus.vissue_valid_o), 64'd0);
    tick();
    @(negedge clk_i);
    check("s3_n2_vvalid", 64'(bus.vissue_valid_o), 64'd1);
    check("s3_scalar", bus.vissue_scalar_o, 64'd0);
    check("s3_no_ven", 64'(ven_cnt - v0), 64'd0);
    tick();
    bus.vissue_ready_i = 1'b1;
    tick();
    bus.vissue_ready_i = 1'b0;

    // scenario 4: saturate with the consumer stalled
    popq.delete();
    for (int i = 1; i <= 5; i++) send(32'(i), 1'b0, 5'd0);
    bus.vins_valid_i   = 1'b1;
    bus.vins_instr_i   = 32'd6;
    bus.vins_use_rs1_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("s4_stall_ready", 64'(bus.vins_ready_o), 64'd0);
      check("s4_full_count", 64'(bus.fifo_count_o), 64'd4);
      tick();
    end
    bus.vissue_ready_i = 1'b1;
    send(32'd6, 1'b0, 5'd0);
    repeat (12) tick();
    check("s4_popn", 64'(popq.size()), 64'd6);
    if (popq.size() == 6)
      for (int k = 0; k < 6; k++)
        check($sformatf("s4_order%0d", k),
              64'(popq[k]), 64'(k + 1));
    bus.vissue_ready_i = 1'b0;

    // scenario 5: flush with three queued and one awaiting grant
    send(32'hA1, 1'b0, 5'd0);
    send(32'hA2, 1'b0, 5'd0);
    send(32'hA3, 1'b0, 5'd0);
    send(32'hA4, 1'b1, 5'd7);
    repeat (2) tick();
    @(negedge clk_i);
    check("s5_count3", 64'(bus.fifo_count_o), 64'd3);
    tick();
    v0 = ven_cnt;
    flush_i = 1'b1;
    @(negedge clk_i);
    check("s5_flush_ready", 64'(bus.vins_ready_o), 64'd0);
    tick();
    flush_i = 1'b0;
    @(negedge clk_i);
    check("s5_count0", 64'(bus.fifo_count_o), 64'd0);
    check("s5_vvalid0", 64'(bus.vissue_valid_o), 64'd0);
    check("s5_ready1", 64'(bus.vins_ready_o), 64'd1);
    tick();
    bus.rf_grant_i = 1'b1;
    @(negedge clk_i);
    check("s5_no_ven_late", 64'(bus.rs1_addr_Ven_o), 64'd0);
    tick();
    bus.rf_grant_i = 1'b0;
    check("s5_ven_total", 64'(ven_cnt - v0), 64'd0);

    // scenario 6: sustained stream wraps the pointers many times
    popq.delete();
    bus.vissue_ready_i = 1'b1;
    bus.rf_grant_i     = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 40; i++)
      send(32'h600 + 32'(i), (i % 3) == 0, 5'(i));
    check("s6_rate", 64'(cyc - c0), 64'd40);
    repeat (5) tick();
    check("s6_popn", 64'(popq.size()), 64'd40);
    if (popq.size() == 40)
      for (int k = 0; k < 40; k++)
        check("s6_order", 64'(popq[k]), 64'h600 + 64'(k));

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bus.vins_valid_i   = ($urandom % 3) != 0;
      bus.vins_instr_i   = $urandom;
      bus.vins_use_rs1_i = $urandom_range(0, 1) == 1;
      bus.vins_rs1_i     = 5'($urandom % 32);
      bus.rf_grant_i     = ($urandom % 3) != 0;
      bus.vissue_ready_i = $urandom_range(0, 1) == 1;
      flush_i            = ($urandom % 60) == 0;
      soft_rstn_i        = ($urandom % 90) != 0;
      tick();
    end
    bus.vins_valid_i   = 1'b0;
    bus.vissue_ready_i = 1'b1;
    bus.rf_grant_i     = 1'b1;
    flush_i            = 1'b0;
    soft_rstn_i        = 1'b1;
    repeat (10) tick();
    @(negedge clk_i);
    check("end_empty", 64'(bus.fifo_count_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
